// File: rtl/nes_button_events_pkg.sv
// nes_button_events_pkg: shared button indices, per-button state encoding and helpers
// for the NES button event block. Build option: NES_BTN_REPEAT_EN enables auto-repeat.
package nes_button_events_pkg;

    localparam int NUM_BTN   = 8;

    // Bit positions within the controller byte
    localparam int BTN_A      = 7;
    localparam int BTN_B      = 6;
    localparam int BTN_SELECT = 5;
    localparam int BTN_START  = 4;
    localparam int BTN_UP     = 3;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_RIGHT  = 0;

    localparam int DEB_CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_REL  = 2'd0,
        ST_HELD = 2'd1,
        ST_RPT  = 2'd2
    } btn_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/nes_button_events_debounce.sv
// nes_button_events_debounce: one button's debounce counter, debounced level, state FSM
// and registered press/release pulses. All activity is gated by the shared sample tick.
// Build option: NES_BTN_REPEAT_EN adds the hold counter and the RPT (auto-repeat) state.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_REL  | debounced level is 0
//   ST_HELD | debounced level is 1, waiting out the initial repeat delay
//   ST_RPT  | debounced level is 1, issuing a press every repeat period
module nes_button_events_debounce
    import nes_button_events_pkg::*;
#(
    parameter int DEBOUNCE_SAMPLES = 4,
    parameter int REPEAT_DELAY     = 400,
    parameter int REPEAT_PERIOD    = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    logic [DEB_CNT_W-1:0] cnt_q, cnt_d;
    logic                 level_q, level_d;
    logic                 press_q, press_d;
    logic                 release_q, release_d;
    btn_state_e           state_q, state_d;

    logic differ;
    logic flip;
    logic rise;
    logic fall;
    logic repeat_hit;

    assign differ = btn_in ^ level_q;
    assign flip   = tick & differ & (cnt_q == DEB_CNT_W'(DEBOUNCE_SAMPLES - 1));
    assign rise   = flip & ~level_q;
    assign fall   = flip & level_q;

`ifdef NES_BTN_REPEAT_EN
    localparam int HOLD_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              delay_hit;
    logic              period_hit;

    // A release tick suppresses any repeat that would land on the same tick.
    assign delay_hit  = tick & ~fall & (state_q == ST_HELD) &
                        (hold_q == HOLD_W'(REPEAT_DELAY - 1));
    assign period_hit = tick & ~fall & (state_q == ST_RPT) &
                        (hold_q == HOLD_W'(REPEAT_PERIOD - 1));
    assign repeat_hit = delay_hit | period_hit;

    // Hold counter: cleared on every transition (incl. RPT->RPT), counts ticks while held
    always_comb begin
        hold_d = hold_q;
        if ((state_d != state_q) || repeat_hit) begin
            hold_d = '0;
        end else if (tick && (state_q != ST_REL)) begin
            hold_d = hold_q + HOLD_W'(1);
        end
    end

    // Hold counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign repeat_hit = 1'b0;
`endif

    // Debounce: count consecutive differing ticks, flip the level on the last one
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (tick) begin
            if (differ) begin
                if (cnt_q == DEB_CNT_W'(DEBOUNCE_SAMPLES - 1)) begin
                    cnt_d   = '0;
                    level_d = ~level_q;
                end else begin
                    cnt_d = cnt_q + DEB_CNT_W'(1);
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    // Debounce and pulse registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_REL;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: press enters HELD, release always returns to REL
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_REL: begin
                if (rise) begin
                    state_d = ST_HELD;
                end
            end
            ST_HELD: begin
                if (fall) begin
                    state_d = ST_REL;
                end else if (repeat_hit) begin
                    state_d = ST_RPT;
                end
            end
            ST_RPT: begin
                if (fall) begin
                    state_d = ST_REL;
                end
            end
            default: state_d = ST_REL;
        endcase
    end

    // FSM outputs: pulse values registered for the cycle after the tick
    always_comb begin
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            ST_REL: begin
                press_d = rise;
            end
            ST_HELD, ST_RPT: begin
                press_d   = repeat_hit;
                release_d = fall;
            end
            default: begin
                press_d   = 1'b0;
                release_d = 1'b0;
            end
        endcase
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule

// File: rtl/nes_button_events.sv
// nes_button_events: turns the eight raw NES button levels into debounced levels and
// one-clock press/release pulses. Holds the shared sample-tick divider and one
// debounce slice per button. Build option: NES_BTN_REPEAT_EN enables press auto-repeat.
module nes_button_events
    import nes_button_events_pkg::*;
#(
    parameter int SAMPLE_DIV       = 100000,
    parameter int DEBOUNCE_SAMPLES = 4,
    parameter int REPEAT_DELAY     = 400,
    parameter int REPEAT_PERIOD    = 100
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic               sample_tick
);

    localparam int DIV_W = $clog2(SAMPLE_DIV);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;

    assign tick = (div_q == DIV_W'(SAMPLE_DIV - 1));

    // Divider wraps after SAMPLE_DIV-1, so the first tick is SAMPLE_DIV cycles after reset
    always_comb begin
        div_d = tick ? '0 : div_q + DIV_W'(1);
    end

    // Divider register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign sample_tick = tick;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        nes_button_events_debounce #(
            .DEBOUNCE_SAMPLES (DEBOUNCE_SAMPLES),
            .REPEAT_DELAY     (REPEAT_DELAY),
            .REPEAT_PERIOD    (REPEAT_PERIOD)
        ) u_btn (
            .clk         (clk),
            .reset       (reset),
            .tick        (tick),
            .btn_in      (btn_in[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i])
        );
    end

endmodule
